stopwatch_fsm: RTL and testbench



---
 rtl/stopwatch_fsm.sv | 160 ++++++++++++++++
 tb/tb_stopwatch_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_fsm.sv
// Stopwatch/timer controller: prescaler, up/down elapsed-time counter, start/stop FSM.
// Define STOPWATCH_LAP_EN to include the lap-capture register and lap edge detector.
module stopwatch_fsm #(
  parameter int unsigned COUNT_W   = 16,
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned MAX_COUNT = 5999,
  parameter int unsigned WRAP      = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_stop,
  input  logic               clear,
  input  logic               lap,
  input  logic               dir,
  input  logic [COUNT_W-1:0] load_val,
  output logic [COUNT_W-1:0] time_o,
  output logic [COUNT_W-1:0] lap_o,
  output logic               lap_valid,
  output logic               running,
  output logic               done,
  output logic [1:0]         state_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]      PrescLast = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]      PrescOne  = PW'(1);
  localparam logic [COUNT_W-1:0] MaxVal    = COUNT_W'(MAX_COUNT);
  localparam logic [COUNT_W-1:0] CountOne  = COUNT_W'(1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_t;

  state_t             state_q;
  logic [PW-1:0]      presc_q;
  logic [COUNT_W-1:0] time_q;
  logic               dir_q;
  logic               ss_q;
  logic               done_q;

  logic               ss_edge;
  logic               tick;
  logic               term_tick;
  logic [COUNT_W-1:0] load_time;

  assign ss_edge   = start_stop & ~ss_q;
  assign tick      = (state_q == StRun) && (presc_q == PrescLast);
  // A wrapping up-counter never terminates; a down-counter terminates on the tick reaching 0.
  assign term_tick = tick && (dir_q ? (time_q == CountOne)
                                    : ((time_q == MaxVal) && (WRAP == 0)));
  assign load_time = dir ? load_val : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      time_q  <= '0;
      dir_q   <= 1'b0;
      ss_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ss_q   <= start_stop;
      done_q <= 1'b0;
      if (clear) begin
        state_q <= StIdle;
        presc_q <= '0;
        time_q  <= load_time;
      end else begin
        case (state_q)
          StIdle: begin
            presc_q <= '0;
            time_q  <= load_time;
            if (ss_edge) begin
              dir_q <= dir;
              if (dir && (load_val == '0)) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q <= StRun;
              end
            end
          end
          StRun: begin
            if (tick) begin
              presc_q <= '0;
              if (dir_q) begin
                time_q <= time_q - CountOne;
              end else if (time_q != MaxVal) begin
                time_q <= time_q + CountOne;
              end else if (WRAP != 0) begin
                time_q <= '0;
              end
            end else begin
              presc_q <= presc_q + PrescOne;
            end
            // Terminal tick beats a same-cycle pause request.
            if (term_tick) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else if (ss_edge) begin
              state_q <= StPause;
            end
          end
          StPause: begin
            if (ss_edge) begin
              state_q <= StRun;
            end
          end
          StDone: begin
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic               lap_q;
  logic               lap_edge;
  logic [COUNT_W-1:0] lap_val_q;
  logic               lap_valid_q;

  assign lap_edge = lap & ~lap_q;

  // Captures the pre-tick count, so a lap on a tick edge records the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q       <= 1'b0;
      lap_val_q   <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_q <= lap;
      if (clear) begin
        lap_val_q   <= '0;
        lap_valid_q <= 1'b0;
      end else if (lap_edge && ((state_q == StRun) || (state_q == StPause))) begin
        lap_val_q   <= time_q;
        lap_valid_q <= 1'b1;
      end
    end
  end

  assign lap_o     = lap_val_q;
  assign lap_valid = lap_valid_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_o      = '0;
  assign lap_valid  = 1'b0;
`endif

  assign time_o  = time_q;
  assign running = (state_q == StRun);
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_stopwatch_fsm.sv
// Self-checking bench for stopwatch_fsm: vector table through a scoreboard queue,
// plus hand-written wrap/terminal, TICK_DIV=1 and asynchronous-reset sequences.
module tb_stopwatch_fsm;

`ifdef STOPWATCH_LAP_EN
  localparam bit LapEn = 1'b1;
`else
  localparam bit LapEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_stop, clear, lap, dir;
  logic [7:0] load_val;

  logic [7:0] time0, lapo0, time1, lapo1, time2, lapo2;
  logic       lapv0, run0, done0, lapv1, run1, done1, lapv2, run2, done2;
  logic [1:0] st0, st1, st2;

  always #5 clk = ~clk;

  stopwatch_fsm #(.COUNT_W(8), .TICK_DIV(4), .MAX_COUNT(9), .WRAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear), .lap(lap), .dir(dir),
    .load_val(load_val), .time_o(time0), .lap_o(lapo0), .lap_valid(lapv0), .running(run0),
    .done(done0), .state_o(st0)
  );

  stopwatch_fsm #(.COUNT_W(8), .TICK_DIV(4), .MAX_COUNT(9), .WRAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear), .lap(lap), .dir(dir),
    .load_val(load_val), .time_o(time1), .lap_o(lapo1), .lap_valid(lapv1), .running(run1),
    .done(done1), .state_o(st1)
  );

  stopwatch_fsm #(.COUNT_W(8), .TICK_DIV(1), .MAX_COUNT(9), .WRAP(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear), .lap(lap), .dir(dir),
    .load_val(load_val), .time_o(time2), .lap_o(lapo2), .lap_valid(lapv2), .running(run2),
    .done(done2), .state_o(st2)
  );

  typedef struct {
    logic       ss, clr, lp, dr;
    logic [7:0] ld;
    int         cyc;
    logic [1:0] st;
    logic [7:0] tm;
    logic       dn;
    logic       lv;
    logic [7:0] lo;
  } vec_t;

  typedef struct {
    logic [1:0] st;
    logic [7:0] tm;
    logic       dn, rn, lv;
    logic [7:0] lo;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic c, input logic l, input logic d,
                              input logic [7:0] ld, input int cyc, input logic [1:0] st,
                              input logic [7:0] tm, input logic dn, input logic lv,
                              input logic [7:0] lo);
    vec_t v;
    v.ss = s; v.clr = c; v.lp = l; v.dr = d; v.ld = ld; v.cyc = cyc;
    v.st = st; v.tm = tm; v.dn = dn; v.lv = lv; v.lo = lo;
    return v;
  endfunction

  task automatic step(input logic s, input logic c, input logic l);
    @(negedge clk);
    start_stop = s; clear = c; lap = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   d0cnt, d1cnt, d2cnt;
    exp_t e;
    rst_n = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0; dir = 1'b0; load_val = 8'd0;

    //       ss clr lp dr ld  cyc st     tm  dn lv lo
    tbl.push_back(mk(0, 1, 0, 0, 0,  1, 2'b00, 0, 0, 0, 0));  // clear, idle
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 2'b01, 0, 0, 0, 0));  // start
    tbl.push_back(mk(0, 0, 0, 0, 0,  3, 2'b01, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 2'b01, 1, 0, 0, 0));  // first tick
    tbl.push_back(mk(0, 0, 0, 0, 0,  8, 2'b01, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  2, 2'b01, 3, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 2'b10, 3, 0, 0, 0));  // pause, prescaler at 3
    tbl.push_back(mk(0, 0, 0, 0, 0, 20, 2'b10, 3, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 2'b01, 3, 0, 0, 0));  // resume
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 2'b01, 4, 0, 0, 0));  // tick 1 cycle later
    tbl.push_back(mk(0, 0, 0, 0, 0,  3, 2'b01, 4, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 2'b10, 5, 0, 0, 0));  // tick + pause
    tbl.push_back(mk(0, 0, 0, 0, 0,  4, 2'b10, 5, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 2'b01, 5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  4, 2'b01, 6, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  1, 2'b01, 6, 0, 1, 6));  // lap at 6
    tbl.push_back(mk(0, 0, 0, 0, 0,  3, 2'b01, 7, 0, 1, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0,  8, 2'b01, 9, 0, 1, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0,  3, 2'b01, 9, 0, 1, 6));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 2'b11, 9, 1, 1, 6));  // terminal tick + ss -> done
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 2'b11, 9, 0, 1, 6));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 2'b11, 9, 0, 1, 6));  // ss ignored in done
    tbl.push_back(mk(0, 0, 0, 0, 0,  6, 2'b11, 9, 0, 1, 6));
    tbl.push_back(mk(0, 0, 1, 0, 0,  1, 2'b11, 9, 0, 1, 6));  // lap ignored in done
    tbl.push_back(mk(0, 1, 0, 0, 0,  1, 2'b00, 0, 0, 0, 0));  // clear
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 2'b01, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  7, 2'b01, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,  1, 2'b00, 0, 0, 0, 0));  // clear on a tick
    tbl.push_back(mk(0, 0, 0, 1, 3,  1, 2'b00, 3, 0, 0, 0));  // idle loads load_val
    tbl.push_back(mk(1, 0, 0, 1, 3,  1, 2'b01, 3, 0, 0, 0));  // down start
    tbl.push_back(mk(0, 0, 0, 0, 7,  4, 2'b01, 2, 0, 0, 0));  // dir/load_val ignored
    tbl.push_back(mk(0, 0, 0, 0, 7,  4, 2'b01, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 7,  3, 2'b01, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 7,  1, 2'b11, 0, 1, 0, 0));  // reaches 0 -> done
    tbl.push_back(mk(0, 0, 0, 0, 7,  1, 2'b11, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0,  1, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0,  1, 2'b11, 0, 1, 0, 0));  // load_val 0 -> done
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 2'b11, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,  1, 2'b00, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(st0), 32'd0);
    chk("rst_time", 32'(time0), 32'd0);
    chk("rst_running", 32'(run0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_lap_o", 32'(lapo0), 32'd0);
    chk("rst_lap_valid", 32'(lapv0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      start_stop = tbl[i].ss; clear = tbl[i].clr; lap = tbl[i].lp;
      dir = tbl[i].dr; load_val = tbl[i].ld;
      e.st = tbl[i].st; e.tm = tbl[i].tm; e.dn = tbl[i].dn;
      e.rn = (tbl[i].st == 2'b01);
      e.lv = LapEn ? tbl[i].lv : 1'b0;
      e.lo = LapEn ? tbl[i].lo : 8'd0;
      sbq.push_back(e);
      repeat (tbl[i].cyc) @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk($sformatf("v%0d_state", i), 32'(st0), 32'(e.st));
      chk($sformatf("v%0d_time", i), 32'(time0), 32'(e.tm));
      chk($sformatf("v%0d_done", i), 32'(done0), 32'(e.dn));
      chk($sformatf("v%0d_running", i), 32'(run0), 32'(e.rn));
      chk($sformatf("v%0d_lap_valid", i), 32'(lapv0), 32'(e.lv));
      chk($sformatf("v%0d_lap_o", i), 32'(lapo0), 32'(e.lo));
    end

    // Terminal behaviour of WRAP=0 vs WRAP=1, and TICK_DIV=1 stepping.
    dir = 1'b0; load_val = 8'd0;
    step(0, 1, 0);
    step(1, 0, 0);
    d0cnt = 0; d1cnt = 0; d2cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      step(0, 0, 0);
      d0cnt += int'(done0); d1cnt += int'(done1); d2cnt += int'(done2);
      if (i == 3) chk("div1_time3", 32'(time2), 32'd3);
      if (i == 10) begin
        chk("div1_done_state", 32'(st2), 32'd3);
        chk("div1_done_time", 32'(time2), 32'd9);
      end
      if (i == 36) begin
        chk("nowrap_at9", 32'(time0), 32'd9);
        chk("wrap_at9", 32'(time1), 32'd9);
        chk("nowrap_run_at9", 32'(st0), 32'd1);
      end
    end
    chk("nowrap_state", 32'(st0), 32'd3);
    chk("nowrap_time", 32'(time0), 32'd9);
    chk("wrap_state", 32'(st1), 32'd1);
    chk("wrap_time", 32'(time1), 32'd0);
    chk("nowrap_done_cycles", 32'(d0cnt), 32'd1);
    chk("wrap_done_cycles", 32'(d1cnt), 32'd0);
    chk("div1_done_cycles", 32'(d2cnt), 32'd1);

    // Asynchronous reset in the middle of a run.
    step(0, 1, 0);
    step(1, 0, 0);
    repeat (5) step(0, 0, 0);
    step(0, 0, 1);
    chk("pre_rst_time", 32'(time0), 32'd1);
    chk("pre_rst_lap_valid", 32'(lapv0), 32'(LapEn));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(st0), 32'd0);
    chk("async_rst_time", 32'(time0), 32'd0);
    chk("async_rst_running", 32'(run0), 32'd0);
    chk("async_rst_done", 32'(done0), 32'd0);
    chk("async_rst_lap_o", 32'(lapo0), 32'd0);
    chk("async_rst_lap_valid", 32'(lapv0), 32'd0);
    @(negedge clk);
    lap = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
